cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) completion port of the reorder buffer among NUM_REQ execution units (ALUs, branch unit, load/store unit).
- Each cycle it picks at most one valid completion by round-robin and drives it as a registered CDB broadcast, one cycle later, to the ROB (done/mispredict marking), reservation stations and the physical register file.
- Losing units hold their result under a valid/ready handshake.

---
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
/*
 * +--------------------------------------------------------------------------+
 * | Module      : cdb_arbiter                                                 |
 * | Description : Round-robin arbiter driving the registered CDB broadcast.   |
 * |               Define CDB_ARB_PERF_EN to add per-unit conflict counters.   |
 * | Revision    : 1.0 - initial release                                       |
 * +--------------------------------------------------------------------------+
 */
`default_nettype none

module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_TAG_W = 4,
  parameter int PREG_W    = 6,
  parameter int DATA_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ROB_TAG_W-1:0] req_tag_i,
  input  logic [NUM_REQ*PREG_W-1:0] req_preg_i,
  input  logic [NUM_REQ-1:0]        req_wen_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_mispredict_i,
  output logic                      cdb_valid_o,
  output logic [ROB_TAG_W-1:0]      cdb_tag_o,
  output logic [PREG_W-1:0]         cdb_preg_o,
  output logic                      cdb_wen_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic                      cdb_mispredict_o
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]     conflict_cnt_o
`endif
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_PTR_W:0]   c_NUM_REQ  = (c_PTR_W+1)'(NUM_REQ);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(NUM_REQ - 1);

  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] w_order [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic [c_PTR_W-1:0] w_grant_idx;
  logic               w_found;
  logic               w_hs;
  logic [c_PTR_W-1:0] w_ptr_next;

  // w_order[k] is the k-th index in priority order, starting at r_rr_ptr
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_order
    logic [c_PTR_W:0] w_sum;
    logic [c_PTR_W:0] w_diff;
    assign w_sum      = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
    assign w_diff     = w_sum - c_NUM_REQ;
    assign w_order[k] = (w_sum >= c_NUM_REQ) ? w_diff[c_PTR_W-1:0] : w_sum[c_PTR_W-1:0];
  end

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid_i[w_order[k]]) begin
        w_found              = 1'b1;
        w_grant_idx          = w_order[k];
        w_grant[w_order[k]]  = 1'b1;
      end
    end
  end

  // Ready is suppressed during reset so nothing handshakes that the arbiter cannot record
  assign req_ready_o = w_grant & {NUM_REQ{~flush_i & rst_n}};
  assign w_hs        = w_found & ~flush_i;
  assign w_ptr_next  = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + c_PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr         <= '0;
      cdb_valid_o      <= 1'b0;
      cdb_tag_o        <= '0;
      cdb_preg_o       <= '0;
      cdb_wen_o        <= 1'b0;
      cdb_data_o       <= '0;
      cdb_mispredict_o <= 1'b0;
    end else begin
      cdb_valid_o <= w_hs;
      if (w_hs) begin
        r_rr_ptr         <= w_ptr_next;
        cdb_tag_o        <= req_tag_i[w_grant_idx*ROB_TAG_W +: ROB_TAG_W];
        cdb_preg_o       <= req_preg_i[w_grant_idx*PREG_W +: PREG_W];
        cdb_wen_o        <= req_wen_i[w_grant_idx];
        cdb_data_o       <= req_data_i[w_grant_idx*DATA_W +: DATA_W];
        cdb_mispredict_o <= req_mispredict_i[w_grant_idx];
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (req_valid_i[i] && !req_ready_o[i] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign conflict_cnt_o[i*16 +: 16] = r_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
/*
 * +--------------------------------------------------------------------------+
 * | Module      : tb_cdb_arbiter                                              |
 * | Description : Directed self-checking bench for cdb_arbiter (4 units).     |
 * | Revision    : 1.0 - initial release                                       |
 * +--------------------------------------------------------------------------+
 */
`default_nettype none

module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [3:0]   valid, wen, mp;
  logic [3:0]   ready;
  logic [15:0]  tags;
  logic [23:0]  pregs;
  logic [127:0] datas;
  logic         cdb_valid, cdb_wen, cdb_mp;
  logic [3:0]   cdb_tag;
  logic [5:0]   cdb_preg;
  logic [31:0]  cdb_data;
`ifdef CDB_ARB_PERF_EN
  logic [63:0]  conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .ROB_TAG_W(4), .PREG_W(6), .DATA_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush),
    .req_valid_i      (valid),
    .req_ready_o      (ready),
    .req_tag_i        (tags),
    .req_preg_i       (pregs),
    .req_wen_i        (wen),
    .req_data_i       (datas),
    .req_mispredict_i (mp),
    .cdb_valid_o      (cdb_valid),
    .cdb_tag_o        (cdb_tag),
    .cdb_preg_o       (cdb_preg),
    .cdb_wen_o        (cdb_wen),
    .cdb_data_o       (cdb_data),
    .cdb_mispredict_o (cdb_mp)
`ifdef CDB_ARB_PERF_EN
    ,
    .conflict_cnt_o   (conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [3:0] t, input logic [5:0] p,
                          input logic w, input logic [31:0] d, input logic m);
    valid[u]        = 1'b1;
    tags[u*4 +: 4]  = t;
    pregs[u*6 +: 6] = p;
    wen[u]          = w;
    datas[u*32 +: 32] = d;
    mp[u]           = m;
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0; flush = 1'b0;
    valid = '0; wen = '0; mp = '0; tags = '0; pregs = '0; datas = '0;

    // Reset state; ready must stay low in reset even with a valid request
    #2;
    valid = 4'b0001;
    #1;
    check("reset_ready", 64'(ready), 64'h0);
    check("reset_cdb_valid", 64'(cdb_valid), 64'h0);
    check("reset_cdb_tag", 64'(cdb_tag), 64'h0);
    check("reset_cdb_data", 64'(cdb_data), 64'h0);
    check("reset_rr_ptr", 64'(dut.r_rr_ptr), 64'h0);
    valid = '0;
    tick;
    rst_n = 1'b1;
    tick;

    // Single request from unit 2
    set_unit(2, 4'd5, 6'd12, 1'b1, 32'hDEADBEEF, 1'b0);
    #1;
    check("single_ready", 64'(ready), 64'h4);
    tick;
    check("single_cdb_valid", 64'(cdb_valid), 64'h1);
    check("single_cdb_tag", 64'(cdb_tag), 64'h5);
    check("single_cdb_preg", 64'(cdb_preg), 64'd12);
    check("single_cdb_data", 64'(cdb_data), 64'hDEADBEEF);
    check("single_cdb_wen", 64'(cdb_wen), 64'h1);
    check("single_rr_ptr", 64'(dut.r_rr_ptr), 64'h3);
    valid = '0;
    #1;
    check("idle_ready", 64'(ready), 64'h0);
    tick;
    check("idle_cdb_valid", 64'(cdb_valid), 64'h0);
    check("idle_cdb_tag_hold", 64'(cdb_tag), 64'h5);

    // Wrap from rr_ptr=3 with units 0 and 3 valid
    set_unit(0, 4'd1, 6'd1, 1'b1, 32'h11, 1'b0);
    set_unit(3, 4'd7, 6'd7, 1'b1, 32'h77, 1'b0);
    #1;
    check("wrap_ready_3", 64'(ready), 64'h8);
    tick;
    check("wrap_tag_3", 64'(cdb_tag), 64'h7);
    check("wrap_rr_ptr_0", 64'(dut.r_rr_ptr), 64'h0);
    valid[3] = 1'b0;
    #1;
    check("wrap_ready_0", 64'(ready), 64'h1);
    tick;
    check("wrap_tag_0", 64'(cdb_tag), 64'h1);
    check("wrap_rr_ptr_1", 64'(dut.r_rr_ptr), 64'h1);
    valid = '0;

    // Bring rr_ptr back to 0 via a lone unit-3 grant
    set_unit(3, 4'd7, 6'd7, 1'b1, 32'h77, 1'b0);
    #1;
    check("realign_ready", 64'(ready), 64'h8);
    tick;
    check("realign_rr_ptr", 64'(dut.r_rr_ptr), 64'h0);

    // All four continuously valid: grants 0,1,2,3,0
    for (int u = 0; u < 4; u++) set_unit(u, 4'(u + 8), 6'(u + 20), 1'b1, 32'(u * 16'h1111), 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_g = 2'(i % 4);
      #1;
      check($sformatf("rr_ready_%0d", i), 64'(ready), 64'(4'b0001 << exp_g));
      tick;
      check($sformatf("rr_cdb_valid_%0d", i), 64'(cdb_valid), 64'h1);
      check($sformatf("rr_cdb_tag_%0d", i), 64'(cdb_tag), 64'(exp_g) + 64'd8);
    end

    // Flush with units 1 and 2 valid; previous broadcast still presented
    valid = 4'b0110;
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(ready), 64'h0);
    check("flush_prev_bcast", 64'(cdb_valid), 64'h1);
    tick;
    check("flush_cdb_valid", 64'(cdb_valid), 64'h0);
    check("flush_rr_ptr", 64'(dut.r_rr_ptr), 64'h1);
    flush = 1'b0;
    #1;
    check("post_flush_ready", 64'(ready), 64'h2);
    tick;
    check("post_flush_tag", 64'(cdb_tag), 64'h9);
    check("post_flush_rr_ptr", 64'(dut.r_rr_ptr), 64'h2);
    valid = '0;

    // Mispredict passthrough from unit 0 (search 2,3,0)
    set_unit(0, 4'd9, 6'd3, 1'b0, 32'h1234, 1'b1);
    #1;
    check("mp_ready", 64'(ready), 64'h1);
    tick;
    check("mp_cdb_mispredict", 64'(cdb_mp), 64'h1);
    check("mp_cdb_tag", 64'(cdb_tag), 64'h9);
    check("mp_cdb_wen", 64'(cdb_wen), 64'h0);
    check("mp_rr_ptr", 64'(dut.r_rr_ptr), 64'h1);
    valid = '0;

    // Mid-operation reset while unit 3 is valid
    set_unit(3, 4'd4, 6'd33, 1'b1, 32'hCAFE, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_cdb_valid", 64'(cdb_valid), 64'h0);
    check("midrst_cdb_tag", 64'(cdb_tag), 64'h0);
    check("midrst_cdb_mp", 64'(cdb_mp), 64'h0);
    check("midrst_cdb_data", 64'(cdb_data), 64'h0);
    check("midrst_cdb_preg", 64'(cdb_preg), 64'h0);
    check("midrst_rr_ptr", 64'(dut.r_rr_ptr), 64'h0);
    check("midrst_ready", 64'(ready), 64'h0);
    rst_n = 1'b1;
    #1;
    check("postrst_ready", 64'(ready), 64'h8);
    tick;
    check("postrst_cdb_valid", 64'(cdb_valid), 64'h1);
    check("postrst_cdb_tag", 64'(cdb_tag), 64'h4);
    check("postrst_cdb_preg", 64'(cdb_preg), 64'd33);
    check("postrst_cdb_data", 64'(cdb_data), 64'hCAFE);
    check("postrst_rr_ptr", 64'(dut.r_rr_ptr), 64'h0);
    valid = '0;

`ifdef CDB_ARB_PERF_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check("perf_reset", conflict_cnt, 64'h0);
    // Unit 1 alone moves rr_ptr to 2 without counting
    set_unit(1, 4'd2, 6'd2, 1'b1, 32'h22, 1'b0);
    tick;
    check("perf_rr_ptr", 64'(dut.r_rr_ptr), 64'h2);
    valid[3] = 1'b1;
    tick;
    valid[3] = 1'b0;
    valid[0] = 1'b1;
    tick;
    valid[0] = 1'b0;
    flush = 1'b1;
    tick;
    check("perf_cnt1_3", 64'(conflict_cnt[16 +: 16]), 64'd3);
    check("perf_cnt0_0", 64'(conflict_cnt[0 +: 16]), 64'd0);
    valid = 4'b0100;
    repeat (70000) @(posedge clk);
    #1;
    check("perf_cnt2_sat", 64'(conflict_cnt[32 +: 16]), 64'hFFFF);
    flush = 1'b0;
    valid = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
